// File: rtl/food_map_controller_pkg.sv
// Shared definitions for the food map slice of the maze game.
//
// Holds the default maze geometry and counter widths, the controller state
// encoding, the colour the renderer paints food boxes with, and a small
// corner-tile helper used when power pellets are enabled
// (macro FOOD_POWER_PELLET_EN).
package food_map_controller_pkg;

  localparam int DEF_GRID_W   = 16;
  localparam int DEF_GRID_H   = 12;
  localparam int DEF_COL_BITS = 4;
  localparam int DEF_ROW_BITS = 4;
  localparam int DEF_CNT_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_t;

  // 12-bit RGB colour of a food box, consumed by the VGA renderer.
  localparam logic [11:0] FOOD_COLOUR = 12'hFC8;

  // The four maze corners are the power-pellet tiles.
  function automatic logic is_corner(input int col, input int row,
                                     input int grid_w, input int grid_h);
    return ((col == 0) || (col == grid_w - 1)) &&
           ((row == 0) || (row == grid_h - 1));
  endfunction

endpackage

// File: rtl/food_map_controller_bitmap_ram.sv
// food_bitmap_ram: one-bit-per-tile food presence store.
//
// One synchronous write port and two synchronous read ports (eat side and
// renderer query side). Reads return the value held before a write landing
// on the same edge, so a tile being cleared still reads as full that cycle.
// Contents are not reset; the controller refills the whole map before use.
//
// Ports:
//   clk         system clock
//   we          write enable
//   waddr       write address
//   wdata       bit to store
//   eat_addr    eat-side read address
//   eat_data    eat-side read data, one cycle after eat_addr
//   query_addr  renderer read address
//   query_data  renderer read data, one cycle after query_addr
module food_bitmap_ram #(
  parameter int DEPTH = 192,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata,
  input  logic [AW-1:0] eat_addr,
  output logic          eat_data,
  input  logic [AW-1:0] query_addr,
  output logic          query_data
);

  logic mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    eat_data   <= mem[eat_addr];
    query_data <= mem[query_addr];
  end

endmodule

// File: rtl/food_map_controller.sv
// food_map_controller: owns the per-tile food map and sequences all access.
//
// A level_start pulse sweeps every tile to "food present" (INIT), then the
// block serves eat requests from the movement logic and tile queries from
// the renderer (RUN), keeping a count of remaining pellets.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   level_start      one-cycle pulse, (re)fill the map
//   eat_req          eat request, held until eat_ack
//   eat_col/eat_row  tile to eat
//   eat_ack          one-cycle acknowledge, one cycle after acceptance
//   eat_hit          with eat_ack: food was present and is now removed
//   query_col/row    renderer tile
//   query_food       food flag for the previous cycle's query
//   food_remaining   pellets left
//   level_clear      map in RUN and no pellets left
//   busy             map refill in progress
//   eat_power        (FOOD_POWER_PELLET_EN) hit tile is a power pellet
//   query_power      (FOOD_POWER_PELLET_EN) queried tile has a power pellet
//
// Build option: define FOOD_POWER_PELLET_EN to treat the four corner tiles
// as power pellets and expose eat_power / query_power.
module food_map_controller
  import food_map_controller_pkg::*;
#(
  parameter int GRID_W   = DEF_GRID_W,
  parameter int GRID_H   = DEF_GRID_H,
  parameter int COL_BITS = DEF_COL_BITS,
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int CNT_BITS = DEF_CNT_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                level_start,
  input  logic                eat_req,
  input  logic [COL_BITS-1:0] eat_col,
  input  logic [ROW_BITS-1:0] eat_row,
  output logic                eat_ack,
  output logic                eat_hit,
  input  logic [COL_BITS-1:0] query_col,
  input  logic [ROW_BITS-1:0] query_row,
  output logic                query_food,
  output logic [CNT_BITS-1:0] food_remaining,
  output logic                level_clear,
  output logic                busy
`ifdef FOOD_POWER_PELLET_EN
  ,
  output logic                eat_power,
  output logic                query_power
`endif
);

  localparam int DEPTH = GRID_W * GRID_H;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [AW-1:0]       LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [CNT_BITS-1:0] FULL_COUNT = CNT_BITS'(DEPTH);
  localparam logic [COL_BITS:0]   COL_LIMIT  = (COL_BITS + 1)'(GRID_W);
  localparam logic [ROW_BITS:0]   ROW_LIMIT  = (ROW_BITS + 1)'(GRID_H);

  state_t        state;
  state_t        state_next;

  logic [AW-1:0] sweep_addr;
  logic [AW-1:0] eat_addr;
  logic [AW-1:0] eat_addr_q;
  logic [AW-1:0] query_addr;
  logic [AW-1:0] ram_waddr;

  logic          eat_in_range;
  logic          query_in_range;
  logic          eat_pend;
  logic          eat_valid_q;
  logic          query_ok_q;
  logic          accept;
  logic          ram_we;
  logic          ram_wdata;
  logic          eat_rd;
  logic          query_rd;

  // Out-of-range coordinates are steered to address 0 so the RAM is never
  // indexed past its end; their results are masked by the range flags.
  assign eat_in_range   = ({1'b0, eat_col} < COL_LIMIT) && ({1'b0, eat_row} < ROW_LIMIT);
  assign query_in_range = ({1'b0, query_col} < COL_LIMIT) && ({1'b0, query_row} < ROW_LIMIT);
  assign eat_addr   = eat_in_range ? (AW'(eat_row) * AW'(GRID_W) + AW'(eat_col)) : '0;
  assign query_addr = query_in_range ? (AW'(query_row) * AW'(GRID_W) + AW'(query_col)) : '0;

  assign eat_ack    = eat_pend;
  assign query_food = query_ok_q & query_rd & (state == RUN);

  food_bitmap_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk        (clk),
    .we         (ram_we),
    .waddr      (ram_waddr),
    .wdata      (ram_wdata),
    .eat_addr   (eat_addr),
    .eat_data   (eat_rd),
    .query_addr (query_addr),
    .query_data (query_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus the shared RAM write port. The ack cycle of an eat
  // clears the tile only when it was full, the counter is non-zero, and no
  // refill is starting in that same cycle.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = eat_addr_q;
    ram_wdata   = 1'b0;
    busy        = 1'b0;
    level_clear = 1'b0;
    eat_hit     = eat_pend & eat_valid_q & eat_rd & ~level_start &
                  (food_remaining != '0);

    case (state)
      IDLE: begin
        if (level_start) begin
          state_next = INIT;
        end
      end
      INIT: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = sweep_addr;
        ram_wdata = 1'b1;
        if (!level_start && (sweep_addr == LAST_ADDR)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        level_clear = (food_remaining == '0);
        accept      = eat_req & ~eat_pend & ~level_start;
        ram_we      = eat_hit;
        if (level_start) begin
          state_next = INIT;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Sweep address, eat handshake bookkeeping and the pellet counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_addr     <= '0;
      eat_pend       <= 1'b0;
      eat_valid_q    <= 1'b0;
      eat_addr_q     <= '0;
      query_ok_q     <= 1'b0;
      food_remaining <= '0;
    end else begin
      eat_pend   <= accept;
      query_ok_q <= (state == RUN) && query_in_range;

      if (accept) begin
        eat_valid_q <= eat_in_range;
        eat_addr_q  <= eat_addr;
      end

      if (level_start) begin
        sweep_addr <= '0;
      end else if (state == INIT) begin
        sweep_addr <= sweep_addr + AW'(1);
      end

      if ((state == INIT) && !level_start && (sweep_addr == LAST_ADDR)) begin
        food_remaining <= FULL_COUNT;
      end else if (eat_hit) begin
        food_remaining <= food_remaining - CNT_BITS'(1);
      end
    end
  end

`ifdef FOOD_POWER_PELLET_EN
  logic eat_corner_q;
  logic query_corner_q;

  // Corner flags travel alongside the RAM reads so they line up with
  // eat_hit and query_food.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eat_corner_q   <= 1'b0;
      query_corner_q <= 1'b0;
    end else begin
      if (accept) begin
        eat_corner_q <= is_corner(int'(eat_col), int'(eat_row), GRID_W, GRID_H);
      end
      query_corner_q <= is_corner(int'(query_col), int'(query_row), GRID_W, GRID_H);
    end
  end

  assign eat_power   = eat_hit & eat_corner_q;
  assign query_power = query_food & query_corner_q;
`endif

endmodule

// File: tb/tb_food_map_controller.sv
// Testbench for food_map_controller: directed scenarios plus randomized eats
// and queries, checked against a tile-array model of the food map.
module tb_food_map_controller;

  localparam int GW    = 16;
  localparam int GH    = 12;
  localparam int CB    = 4;
  localparam int RB    = 4;
  localparam int NB    = 8;
  localparam int TILES = GW * GH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          level_start = 1'b0;
  logic          eat_req = 1'b0;
  logic [CB-1:0] eat_col = '0;
  logic [RB-1:0] eat_row = '0;
  logic          eat_ack;
  logic          eat_hit;
  logic [CB-1:0] query_col = '0;
  logic [RB-1:0] query_row = '0;
  logic          query_food;
  logic [NB-1:0] food_remaining;
  logic          level_clear;
  logic          busy;
`ifdef FOOD_POWER_PELLET_EN
  logic          eat_power;
  logic          query_power;
`endif

  int compared = 0;
  int mismatched = 0;

  bit foodMap [TILES];
  int pellets = 0;

  food_map_controller #(
    .GRID_W(GW), .GRID_H(GH), .COL_BITS(CB), .ROW_BITS(RB), .CNT_BITS(NB)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .level_start    (level_start),
    .eat_req        (eat_req),
    .eat_col        (eat_col),
    .eat_row        (eat_row),
    .eat_ack        (eat_ack),
    .eat_hit        (eat_hit),
    .query_col      (query_col),
    .query_row      (query_row),
    .query_food     (query_food),
    .food_remaining (food_remaining),
    .level_clear    (level_clear),
    .busy           (busy)
`ifdef FOOD_POWER_PELLET_EN
    ,
    .eat_power      (eat_power),
    .query_power    (query_power)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit inRange(input int c, input int r);
    return (c < GW) && (r < GH);
  endfunction

  function automatic bit isCorner(input int c, input int r);
    return ((c == 0) || (c == GW - 1)) && ((r == 0) || (r == GH - 1));
  endfunction

  function automatic bit modelFood(input int c, input int r);
    if (!inRange(c, r)) return 1'b0;
    return foodMap[r * GW + c];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ack"}, eat_ack, 0);
    checkOutput({tag, "_hit"}, eat_hit, 0);
    checkOutput({tag, "_qfood"}, query_food, 0);
    checkOutput({tag, "_count"}, food_remaining, 0);
    checkOutput({tag, "_clear"}, level_clear, 0);
    checkOutput({tag, "_busy"}, busy, 0);
`ifdef FOOD_POWER_PELLET_EN
    checkOutput({tag, "_epow"}, eat_power, 0);
    checkOutput({tag, "_qpow"}, query_power, 0);
`endif
  endtask

  // Counts refill cycles from the current point; a refill always ends with
  // every tile full.
  task automatic waitInit(input int alreadySeen);
    int n;
    n = alreadySeen;
    @(negedge clk);
    while ((busy === 1'b1) && (n < 400)) begin
      n++;
      @(negedge clk);
    end
    checkOutput("busy_cycles", n, TILES);
    for (int i = 0; i < TILES; i++) foodMap[i] = 1'b1;
    pellets = TILES;
    checkOutput("count_after_init", food_remaining, pellets);
    checkOutput("clear_after_init", level_clear, 0);
  endtask

  task automatic startLevel();
    tick();
    level_start = 1'b1;
    tick();
    level_start = 1'b0;
    waitInit(0);
  endtask

  // One eat transaction; the renderer queries the same tile meanwhile, so
  // the query taken in the ack cycle must still see the pre-clear value.
  task automatic applyStimulus(input int c, input int r);
    bit expHit;
    tick();
    eat_req   = 1'b1;
    eat_col   = CB'(c);
    eat_row   = RB'(r);
    query_col = CB'(c);
    query_row = RB'(r);
    @(negedge clk);
    checkOutput("ack_early", eat_ack, 0);
    tick();
    @(negedge clk);
    expHit = modelFood(c, r) && (pellets > 0);
    checkOutput("eat_ack", eat_ack, 1);
    checkOutput("eat_hit", eat_hit, expHit);
`ifdef FOOD_POWER_PELLET_EN
    checkOutput("eat_power", eat_power, expHit && isCorner(c, r));
`endif
    tick();
    eat_req = 1'b0;
    @(negedge clk);
    checkOutput("query_rbw", query_food, modelFood(c, r));
    if (expHit) begin
      foodMap[r * GW + c] = 1'b0;
      pellets--;
    end
    checkOutput("count", food_remaining, pellets);
    checkOutput("clear", level_clear, pellets == 0);
    checkOutput("ack_low", eat_ack, 0);
  endtask

  task automatic applyQuery(input int c, input int r);
    tick();
    query_col = CB'(c);
    query_row = RB'(r);
    tick();
    @(negedge clk);
    checkOutput("query_food", query_food, modelFood(c, r));
`ifdef FOOD_POWER_PELLET_EN
    checkOutput("query_power", query_power, modelFood(c, r) && isCorner(c, r));
`endif
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int acks;
    logic [7:0] ackPattern;

    // Reset state.
    #12;
    checkAllZero("reset");
    tick();
    rst_n = 1'b1;

    // IDLE ignores eat requests.
    tick();
    eat_req = 1'b1;
    eat_col = 4'd1;
    eat_row = 4'd1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (eat_ack === 1'b1) acks++;
      tick();
    end
    eat_req = 1'b0;
    checkOutput("idle_acks", acks, 0);
    checkOutput("idle_qfood", query_food, 0);

    // Refill and first query.
    startLevel();
    applyQuery(3, 2);

    // Same tile twice, then confirm it reads empty.
    applyStimulus(5, 4);
    applyStimulus(5, 4);
    applyQuery(5, 4);

    // Out-of-range rows are acked without effect.
    applyStimulus(3, 12);
    applyStimulus(15, 14);
    applyQuery(3, 0);
    applyQuery(0, 0);

    // A held request on an out-of-range tile acks every other cycle.
    tick();
    eat_req = 1'b1;
    eat_col = 4'd7;
    eat_row = 4'd13;
    ackPattern = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ackPattern = {ackPattern[6:0], eat_ack};
      if (eat_ack === 1'b1) checkOutput("held_hit", eat_hit, 0);
      tick();
    end
    eat_req = 1'b0;
    checkOutput("held_ack_pattern", ackPattern, 8'b0101_0101);
    checkOutput("held_count", food_remaining, pellets);

    // Randomized eats and queries.
    for (int i = 0; i < 120; i++) begin
      applyStimulus(int'($urandom_range(0, GW - 1)), int'($urandom_range(0, GH + 1)));
      if ($urandom_range(0, 2) == 0) begin
        applyQuery(int'($urandom_range(0, GW - 1)), int'($urandom_range(0, GH - 1)));
      end
    end

    // Clear the whole map row by row, then one more eat on an empty map.
    for (int r = 0; r < GH; r++) begin
      for (int c = 0; c < GW; c++) begin
        applyStimulus(c, r);
      end
    end
    checkOutput("sweep_clear", level_clear, 1);
    checkOutput("sweep_count", food_remaining, 0);
    applyStimulus(0, 0);
    checkOutput("post_clear_count", food_remaining, 0);

    // Refill, eat a little, then abort an eat in its ack cycle.
    startLevel();
    applyStimulus(15, 11);
    applyStimulus(7, 7);
    applyStimulus(0, 0);
    tick();
    eat_req = 1'b1;
    eat_col = 4'd2;
    eat_row = 4'd2;
    tick();
    level_start = 1'b1;
    @(negedge clk);
    checkOutput("abort_ack", eat_ack, 1);
    checkOutput("abort_hit", eat_hit, 0);
`ifdef FOOD_POWER_PELLET_EN
    checkOutput("abort_power", eat_power, 0);
`endif
    tick();
    level_start = 1'b0;
    eat_req = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", busy, 1);
    waitInit(1);
    applyQuery(2, 2);
    applyQuery(15, 11);
    applyQuery(7, 7);

    // Reset during an eat: the pending ack never appears.
    tick();
    eat_req = 1'b1;
    eat_col = 4'd4;
    eat_row = 4'd4;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkAllZero("run_reset");
    tick();
    @(negedge clk);
    checkOutput("run_reset_noack", eat_ack, 0);
    tick();
    rst_n = 1'b1;
    eat_req = 1'b0;

    // Reset in the middle of a refill.
    tick();
    level_start = 1'b1;
    tick();
    level_start = 1'b0;
    for (int i = 0; i < 50; i++) @(negedge clk);
    checkOutput("mid_init_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    checkAllZero("init_reset");
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("idle_after_reset_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
